// File: rtl/var_length_bytes2packets.sv
// Byte-to-symbol packer and packet framer with run-time packet length.
// Ports: clock_clk/reset_reset; cfg_symbols_per_packet; asi_in0_* byte sink;
// aso_out0_* symbol source with SOP/EOP and backpressure; stat_packets count.
module var_length_bytes2packets #(
  parameter int MAX_SYMBOLS_PER_PACKET = 16,
  parameter int BYTES_PER_SYMBOL       = 4,
  parameter int BITS_PER_BYTES         = 8,
  parameter bit BIG_ENDIAN             = 1'b1,
  parameter int LEN_W = $clog2(MAX_SYMBOLS_PER_PACKET + 1)
) (
  input  logic                                     clock_clk,
  input  logic                                     reset_reset,
  input  logic [LEN_W-1:0]                         cfg_symbols_per_packet,
  input  logic [BITS_PER_BYTES-1:0]                asi_in0_data,
  input  logic                                     asi_in0_valid,
  output logic                                     asi_in0_ready,
  output logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] aso_out0_data,
  output logic                                     aso_out0_valid,
  input  logic                                     aso_out0_ready,
  output logic                                     aso_out0_startofpacket,
  output logic                                     aso_out0_endofpacket,
  output logic [31:0]                              stat_packets
);
  localparam int B   = BYTES_PER_SYMBOL;
  localparam int W   = BITS_PER_BYTES;
  localparam int SW  = B * W;
  localparam int BCW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(B - 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_SYMBOLS_PER_PACKET);

  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [SW-1:0]    asm_q, asm_d;
  logic [SW-1:0]    odata_q, odata_d;
  logic             ovalid_q, ovalid_d;
  logic             osop_q, osop_d;
  logic             oeop_q, oeop_d;
  logic [31:0]      stat_q, stat_d;

  logic             in_rdy, in_fire, out_fire;
  logic             last_byte, first_byte, sym_done, eop_now;
  logic [LEN_W-1:0] cfg_len, cur_len;

  // Control state is implied by the counters: IDLE when both are zero,
  // STALL when the last byte waits on a full unaccepted output, else FILL.
  assign last_byte  = (byte_cnt_q == LAST_BYTE);
  assign first_byte = (byte_cnt_q == '0) && (sym_cnt_q == '0);
  assign in_rdy     = !reset_reset &&
                      (!last_byte || !ovalid_q || aso_out0_ready);
  assign in_fire    = asi_in0_valid && in_rdy;
  assign out_fire   = ovalid_q && aso_out0_ready;
  assign sym_done   = in_fire && last_byte;

  always_comb begin
    cfg_len = cfg_symbols_per_packet;
    if (cfg_symbols_per_packet == '0)
      cfg_len = LEN_W'(1);
    else if (cfg_symbols_per_packet > MAX_LEN)
      cfg_len = MAX_LEN;
  end

  // With one-byte symbols the packet's first byte also ends a symbol,
  // so EOP must see the length being latched on that same edge.
  assign cur_len = first_byte ? cfg_len : pkt_len_q;
  assign eop_now = (sym_cnt_q == cur_len - LEN_W'(1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    pkt_len_d  = pkt_len_q;
    asm_d      = asm_q;
    odata_d    = odata_q;
    ovalid_d   = ovalid_q;
    osop_d     = osop_q;
    oeop_d     = oeop_q;
    stat_d     = stat_q;
    if (in_fire) begin
      for (int k = 0; k < B; k++) begin
        if (byte_cnt_q == BCW'(k))
          asm_d[(BIG_ENDIAN ? (B - 1 - k) : k) * W +: W] = asi_in0_data;
      end
      if (first_byte)
        pkt_len_d = cfg_len;
      byte_cnt_d = last_byte ? '0 : byte_cnt_q + BCW'(1);
    end
    if (out_fire) begin
      ovalid_d = 1'b0;
      if (oeop_q)
        stat_d = stat_q + 32'd1;
    end
    if (sym_done) begin
      odata_d   = asm_d;
      ovalid_d  = 1'b1;
      osop_d    = (sym_cnt_q == '0);
      oeop_d    = eop_now;
      sym_cnt_d = eop_now ? '0 : sym_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      byte_cnt_q <= '0;
      sym_cnt_q  <= '0;
      pkt_len_q  <= '0;
      asm_q      <= '0;
      odata_q    <= '0;
      ovalid_q   <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      stat_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      pkt_len_q  <= pkt_len_d;
      asm_q      <= asm_d;
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      stat_q     <= stat_d;
    end
  end

  // Outputs read zero for the whole time reset is held.
  assign asi_in0_ready          = in_rdy;
  assign aso_out0_valid         = ovalid_q && !reset_reset;
  assign aso_out0_data          = reset_reset ? '0 : odata_q;
  assign aso_out0_startofpacket = osop_q && !reset_reset;
  assign aso_out0_endofpacket   = oeop_q && !reset_reset;
  assign stat_packets           = reset_reset ? '0 : stat_q;
endmodule

// File: tb/tb_var_length_bytes2packets.sv
// Scoreboard bench: big- and little-endian instances share one stream;
// a byte-level reference model fills the queue, a monitor drains it.
module tb_var_length_bytes2packets;
  localparam int MAXS = 16;
  localparam int B    = 4;
  localparam int W    = 8;
  localparam int LW   = $clog2(MAXS + 1);
  localparam int SW   = B * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] cfg = '0;
  logic [W-1:0]  din = '0;
  logic          vin = 1'b0;
  logic          oready = 1'b0;
  logic          rdy_a, rdy_b, vout_a, vout_b;
  logic          sop_a, sop_b, eop_a, eop_b;
  logic [SW-1:0] dout_a, dout_b;
  logic [31:0]   stat_a, stat_b;

  var_length_bytes2packets #(
    .MAX_SYMBOLS_PER_PACKET(MAXS), .BYTES_PER_SYMBOL(B),
    .BITS_PER_BYTES(W), .BIG_ENDIAN(1'b1)
  ) u_be (
    .clock_clk(clk), .reset_reset(rst),
    .cfg_symbols_per_packet(cfg),
    .asi_in0_data(din), .asi_in0_valid(vin), .asi_in0_ready(rdy_a),
    .aso_out0_data(dout_a), .aso_out0_valid(vout_a),
    .aso_out0_ready(oready),
    .aso_out0_startofpacket(sop_a), .aso_out0_endofpacket(eop_a),
    .stat_packets(stat_a)
  );

  var_length_bytes2packets #(
    .MAX_SYMBOLS_PER_PACKET(MAXS), .BYTES_PER_SYMBOL(B),
    .BITS_PER_BYTES(W), .BIG_ENDIAN(1'b0)
  ) u_le (
    .clock_clk(clk), .reset_reset(rst),
    .cfg_symbols_per_packet(cfg),
    .asi_in0_data(din), .asi_in0_valid(vin), .asi_in0_ready(rdy_b),
    .aso_out0_data(dout_b), .aso_out0_valid(vout_b),
    .aso_out0_ready(oready),
    .aso_out0_startofpacket(sop_b), .aso_out0_endofpacket(eop_b),
    .stat_packets(stat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] be;
    logic [SW-1:0] le;
    logic          sop;
    logic          eop;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mode = 0;
  int         m_byte = 0;
  int         m_sym = 0;
  int         m_len = 1;
  int         exp_pkts = 0;
  logic [W-1:0] m_bytes [0:B-1];

  function automatic int clampl(input int c);
    if (c == 0) return 1;
    if (c > MAXS) return MAXS;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_byte(input logic [W-1:0] d);
    exp_t e;
    if (m_byte == 0 && m_sym == 0) m_len = clampl(int'(cfg));
    m_bytes[m_byte] = d;
    m_byte++;
    if (m_byte == B) begin
      e.be = '0;
      e.le = '0;
      for (int k = 0; k < B; k++) begin
        e.be = (e.be << W) | SW'(m_bytes[k]);
        e.le = e.le | (SW'(m_bytes[k]) << (k * W));
      end
      e.sop = (m_sym == 0);
      e.eop = (m_sym == m_len - 1);
      q.push_back(e);
      m_byte = 0;
      if (e.eop) begin
        m_sym = 0;
        exp_pkts++;
      end else begin
        m_sym++;
      end
    end
  endtask

  task automatic send_byte(input logic [W-1:0] d);
    int t = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      vin = 1'b1;
      din = d;
      #2;
      if (rdy_a) begin
        model_byte(d);
        done = 1;
      end else if (++t > 200) begin
        chk("in_ready_timeout", 128'(rdy_a), 128'(1));
        done = 1;
      end
    end
    @(posedge clk);
    #1 vin = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    mode = 0;
    do begin
      @(negedge clk);
      #3;
      t++;
    end while ((q.size() != 0 || vout_a) && t < 300);
    if (t >= 300) chk("drain_timeout", 128'(q.size()), 128'(0));
    chk("stat_packets", {stat_a, stat_b},
        {32'(exp_pkts), 32'(exp_pkts)});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    vin = 1'b0;
    q.delete();
    m_byte = 0;
    m_sym = 0;
    exp_pkts = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs",
        {rdy_a, rdy_b, vout_a, vout_b, sop_a, sop_b, eop_a, eop_b,
         dout_a, dout_b, stat_a, stat_b}, '0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_cfg();
    if ($urandom_range(0, 19) == 0)
      return LW'($urandom_range(MAXS + 1, (1 << LW) - 1));
    return LW'($urandom_range(0, 5));
  endfunction

  initial forever begin
    @(negedge clk);
    case (mode)
      0:       oready = 1'b1;
      1:       oready = 1'b0;
      default: oready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (!rst && (vout_a || vout_b)) begin
      if (q.size() == 0) begin
        chk("unexpected_symbol", 128'({vout_a, vout_b}), 128'(0));
      end else begin
        mon_e = q[0];
        chk("symbol",
            {vout_a, vout_b, dout_a, dout_b, sop_a, sop_b, eop_a, eop_b},
            {2'b11, mon_e.be, mon_e.le, mon_e.sop, mon_e.sop,
             mon_e.eop, mon_e.eop});
        if (oready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_dut();

    mode = 0;
    cfg = LW'(2);
    for (int i = 1; i <= 8; i++) send_byte(W'(i));
    drain();

    mode = 1;
    cfg = LW'(2);
    for (int i = 1; i <= 7; i++) send_byte(W'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vin = 1'b1;
      din = W'(8);
      #2;
      chk("stall_in_ready", 128'({rdy_a, rdy_b}), 128'(0));
    end
    mode = 0;
    send_byte(W'(8));
    drain();

    cfg = LW'(0);
    for (int i = 0; i < B; i++) send_byte(W'(8'h10 + i));
    drain();
    cfg = '1;
    for (int i = 0; i < MAXS * B; i++) send_byte(W'(i));
    drain();
    cfg = LW'(3);
    send_byte(W'(8'h40));
    cfg = LW'(1);
    for (int i = 1; i < 3 * B; i++) send_byte(W'(8'h40 + i));
    for (int i = 0; i < B; i++) send_byte(W'(8'h60 + i));
    drain();

    mode = 1;
    cfg = LW'(2);
    for (int i = 1; i <= 6; i++) send_byte(W'(i));
    reset_dut();
    mode = 0;
    for (int i = 0; i < 8; i++) send_byte(W'(8'hA0 + i));
    drain();

    reset_dut();
    mode = 2;
    cfg = rand_cfg();
    while (exp_pkts < 1000 || m_byte != 0 || m_sym != 0) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if ($urandom_range(0, 15) == 0) cfg = rand_cfg();
      send_byte(W'($urandom));
    end
    drain();
    chk("stat_1000", 128'(stat_a), 128'(1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
